// File: rtl/demux13_7_sched_pkg.sv
// Shared constants and encodings for the 13-bit / 7-channel scheduler.
// Module parameters take their defaults from here.
package demux13_7_sched_pkg;

    localparam int WIDTH     = 13;
    localparam int NCH       = 7;
    localparam int SELW      = 3;
    localparam int STALL_MAX = 15;

    // Error and stall counters share one saturating width.
    localparam int                CNT_W   = 8;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef enum logic {
        MODE_RR   = 1'b0,
        MODE_ADDR = 1'b1
    } mode_e;

endpackage

// File: rtl/demux13_7_sched_ptr.sv
// Mod-NCH wrapping pointer with advance/load controls.
// Also exposes the wrapped successor of an arbitrary channel, used for stall retarget.
module demux_rr_ptr #(
    parameter int NCH  = demux13_7_sched_pkg::NCH,
    parameter int SELW = demux13_7_sched_pkg::SELW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_adv,
    input  logic            i_load,
    input  logic [SELW-1:0] i_load_val,
    input  logic [SELW-1:0] i_cur,
    output logic [SELW-1:0] o_ptr,
    output logic [SELW-1:0] o_ptr_inc,
    output logic [SELW-1:0] o_cur_inc
);

    logic [SELW-1:0] r_ptr;

    function automatic logic [SELW-1:0] f_wrap_inc(input logic [SELW-1:0] v);
        return (v == SELW'(NCH - 1)) ? '0 : v + SELW'(1);
    endfunction

    assign o_ptr     = r_ptr;
    assign o_ptr_inc = f_wrap_inc(r_ptr);
    assign o_cur_inc = f_wrap_inc(i_cur);

    // A load (retarget) and an advance (delivery) never coincide; load wins anyway.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_adv) begin
            r_ptr <= o_ptr_inc;
        end
    end

endmodule

// File: rtl/demux13_7_sched.sv
// Valid/ready scheduler: holds one word and presents it to one of NCH channels,
// chosen round-robin or by a per-word destination, with stall retargeting in round-robin.
module demux13_7_sched #(
    parameter int WIDTH     = demux13_7_sched_pkg::WIDTH,
    parameter int NCH       = demux13_7_sched_pkg::NCH,
    parameter int SELW      = demux13_7_sched_pkg::SELW,
    parameter int STALL_MAX = demux13_7_sched_pkg::STALL_MAX
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic [SELW-1:0]  i_in_dest,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_out_data,
    output logic [SELW-1:0]  o_select,
    output logic [NCH-1:0]   o_out_valid,
    input  logic [NCH-1:0]   i_out_ready,
    output logic [7:0]       o_err_cnt
);

    import demux13_7_sched_pkg::*;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_out_data;
    logic [SELW-1:0]    r_select;
    mode_e              r_held_mode;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_hold;
    logic               w_fire;
    logic               w_in_ready;
    logic               w_accept;
    mode_e              w_mode_in;
    logic               w_illegal;
    logic               w_load;
    logic               w_rr_adv;
    logic               w_stalled;
    logic               w_retarget;
    logic [SELW-1:0]    w_ptr;
    logic [SELW-1:0]    w_ptr_inc;
    logic [SELW-1:0]    w_sel_inc;
    logic [SELW-1:0]    w_rr_target;
    logic [SELW-1:0]    w_target;

    assign w_hold     = (r_state == ST_HOLD);
    assign w_fire     = w_hold & i_out_ready[r_select];
    assign w_in_ready = i_rst_n & (~w_hold | w_fire);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_mode_in  = mode_e'(i_mode);

    // Illegal destinations are consumed and counted but never loaded.
    assign w_illegal  = (w_mode_in == MODE_ADDR) &
                        ({1'b0, i_in_dest} >= (SELW+1)'(NCH));
    assign w_load     = w_accept & ~w_illegal;

    assign w_rr_adv   = w_fire & (r_held_mode == MODE_RR);
    assign w_stalled  = w_hold & ~w_fire;

    // Retarget on the edge that ends the STALL_MAX-th cycle spent on one channel.
    assign w_retarget = w_stalled & (r_held_mode == MODE_RR) &
                        (r_stall_cnt == CNT_W'(STALL_MAX - 1));

    // A delivery in the same cycle as an accept hands the new word the advanced pointer.
    assign w_rr_target = w_rr_adv ? w_ptr_inc : w_ptr;
    assign w_target    = (w_mode_in == MODE_ADDR) ? i_in_dest : w_rr_target;

    demux_rr_ptr #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_ptr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_adv      (w_rr_adv),
        .i_load     (w_retarget),
        .i_load_val (w_sel_inc),
        .i_cur      (r_select),
        .o_ptr      (w_ptr),
        .o_ptr_inc  (w_ptr_inc),
        .o_cur_inc  (w_sel_inc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_load)            w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_fire && !w_load) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_data  <= '0;
            r_select    <= '0;
            r_held_mode <= MODE_RR;
            r_stall_cnt <= '0;
        end else if (w_load) begin
            r_out_data  <= i_in_data;
            r_select    <= w_target;
            r_held_mode <= w_mode_in;
            r_stall_cnt <= '0;
        end else if (w_retarget) begin
            r_select    <= w_sel_inc;
            r_stall_cnt <= '0;
        end else if (w_stalled && r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_illegal && r_err_cnt != CNT_MAX) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_data  = r_out_data;
    assign o_select    = r_select;
    assign o_out_valid = w_hold ? (NCH'(1) << r_select) : '0;
    assign o_err_cnt   = r_err_cnt;

    a_valid_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_out_valid));
    a_select_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ({1'b0, r_select} < (SELW+1)'(NCH)));

endmodule

// File: tb/tb_demux13_7_sched.sv
// Bench for demux13_7_sched: directed vector table, hand sequences for stall and reset
// corners, then randomized traffic against a word-level reference model.
module tb_demux13_7_sched;

    localparam int WIDTH     = 13;
    localparam int NCH       = 7;
    localparam int SELW      = 3;
    localparam int STALL_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [SELW-1:0]  in_dest = '0;
    logic             mode = 1'b0;
    logic [NCH-1:0]   out_ready = '0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  select;
    logic [NCH-1:0]   out_valid;
    logic [7:0]       err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int dut_del = 0;

    // Reference model: one optional held word, its channel, and how long it has waited there.
    bit               m_busy = 0;
    bit               m_addr = 0;
    int               m_chan = 0;
    int               m_ptr  = 0;
    int               m_err  = 0;
    int               m_wait = 0;
    int               m_del  = 0;
    logic [WIDTH-1:0] m_word = '0;

    always #5 clk = ~clk;

    demux13_7_sched #(
        .WIDTH     (WIDTH),
        .NCH       (NCH),
        .SELW      (SELW),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_dest   (in_dest),
        .i_mode      (mode),
        .o_out_data  (out_data),
        .o_select    (select),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_err_cnt   (err_cnt)
    );

    typedef struct {
        logic             rst;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic [SELW-1:0]  dest;
        logic             md;
        logic [NCH-1:0]   ordy;
        logic             e_rdy;
        logic [NCH-1:0]   e_ov;
        logic [SELW-1:0]  e_sel;
        logic [WIDTH-1:0] e_d;
        logic [7:0]       e_err;
    } vec_t;

    function automatic vec_t mk(logic rst, logic iv, logic [WIDTH-1:0] d, logic [SELW-1:0] dest,
                                logic md, logic [NCH-1:0] ordy, logic e_rdy, logic [NCH-1:0] e_ov,
                                logic [SELW-1:0] e_sel, logic [WIDTH-1:0] e_d, logic [7:0] e_err);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.dest = dest; v.md = md; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sel = e_sel; v.e_d = e_d; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(logic r, logic v, logic [WIDTH-1:0] d, logic [SELW-1:0] ds,
                         logic md, logic [NCH-1:0] ordy);
        rst_n = r; in_valid = v; in_data = d; in_dest = ds; mode = md; out_ready = ordy;
    endtask

    task automatic check(string nm, logic rdy, logic [NCH-1:0] ov, logic [SELW-1:0] sel,
                         logic [WIDTH-1:0] d, logic [7:0] err);
        n_chk++;
        if (in_ready !== rdy || out_valid !== ov || select !== sel || out_data !== d || err_cnt !== err) begin
            n_err++;
            $display("FAIL %s: got rdy=%0b ov=%02h sel=%0d data=%04h err=%0d, want rdy=%0b ov=%02h sel=%0d data=%04h err=%0d",
                     nm, in_ready, out_valid, select, out_data, err_cnt, rdy, ov, sel, d, err);
        end
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        bit rdy, deliver;
        if (!rst_n) begin
            m_busy = 0; m_addr = 0; m_chan = 0; m_ptr = 0; m_err = 0; m_wait = 0; m_word = '0;
        end else begin
            deliver = m_busy && out_ready[m_chan];
            rdy     = !m_busy || deliver;
            if (deliver) begin
                m_del++;
                if (!m_addr) m_ptr = (m_ptr + 1) % NCH;
                m_busy = 0;
            end else if (m_busy) begin
                m_wait++;
                if (!m_addr && m_wait == STALL_MAX) begin
                    m_chan = (m_chan + 1) % NCH;
                    m_ptr  = m_chan;
                    m_wait = 0;
                end
            end
            if (in_valid && rdy) begin
                if (mode && int'(in_dest) >= NCH) begin
                    if (m_err < 255) m_err++;
                end else begin
                    m_busy = 1;
                    m_word = in_data;
                    m_addr = mode;
                    m_chan = mode ? int'(in_dest) : m_ptr;
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic tick(string nm, bit has_exp, logic rdy, logic [NCH-1:0] ov,
                        logic [SELW-1:0] sel, logic [WIDTH-1:0] d, logic [7:0] err);
        logic [NCH-1:0] m_ov;
        @(negedge clk);
        m_ov = m_busy ? NCH'(1 << m_chan) : '0;
        check({nm, "/model"}, rst_n && (!m_busy || out_ready[m_chan]), m_ov,
              SELW'(m_chan), m_word, 8'(m_err));
        if (has_exp) check(nm, rdy, ov, sel, d, err);
        if (rst_n && |(out_valid & out_ready)) dut_del++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    vec_t           vecs[$];
    logic [NCH-1:0] blk;

    initial begin
        // Unchecked first edge so every checked cycle starts from a known state.
        drive(0, 1, 13'h1FFF, 0, 0, 7'h7F);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 13'h1FFF, 0, 0, 7'h7F, 0, 7'h00, 0, 13'h0000, 0));
        // Round-robin sweep: words 1..8 on channels 0..6,0, one per cycle.
        vecs.push_back(mk(1, 1, 13'h0001, 0, 0, 7'h7F, 1, 7'h00, 0, 13'h0000, 0));
        for (int k = 2; k <= 8; k++)
            vecs.push_back(mk(1, 1, 13'(k), 0, 0, 7'h7F, 1, 7'(1 << (k - 2)), 3'(k - 2), 13'(k - 1), 0));
        vecs.push_back(mk(1, 0, 13'h0000, 0, 0, 7'h7F, 1, 7'h01, 0, 13'h0008, 0));
        vecs.push_back(mk(1, 0, 13'h0000, 0, 0, 7'h7F, 1, 7'h00, 0, 13'h0008, 0));
        // Addressed: dest 3, dest 6, then an illegal dest 7 from idle.
        vecs.push_back(mk(1, 1, 13'h1C23, 3, 1, 7'h7F, 1, 7'h00, 0, 13'h0008, 0));
        vecs.push_back(mk(1, 1, 13'h0001, 6, 1, 7'h7F, 1, 7'h08, 3, 13'h1C23, 0));
        vecs.push_back(mk(1, 0, 13'h0000, 0, 1, 7'h7F, 1, 7'h40, 6, 13'h0001, 0));
        vecs.push_back(mk(1, 1, 13'h0AAA, 7, 1, 7'h7F, 1, 7'h00, 6, 13'h0001, 0));
        vecs.push_back(mk(1, 0, 13'h0000, 0, 0, 7'h7F, 1, 7'h00, 6, 13'h0001, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].dest, vecs[i].md, vecs[i].ordy);
            tick($sformatf("vec%0d", i), 1, vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_sel,
                 vecs[i].e_d, vecs[i].e_err);
        end

        // Addressed word on a backpressured channel waits indefinitely.
        drive(1, 1, 13'h1234, 4, 1, 7'h6F);
        tick("addr_acc", 1, 1, 7'h00, 6, 13'h0001, 1);
        drive(1, 1, 13'h0F0F, 4, 1, 7'h6F);
        for (int i = 0; i < 40; i++)
            tick("addr_stall", 1, 0, 7'h10, 4, 13'h1234, 1);
        drive(1, 0, 13'h0000, 0, 1, 7'h7F);
        tick("addr_release", 1, 1, 7'h10, 4, 13'h1234, 1);
        tick("addr_idle", 1, 1, 7'h00, 4, 13'h1234, 1);

        // Reset while holding a round-robin word.
        drive(1, 1, 13'h0555, 0, 0, 7'h00);
        tick("mid_acc", 1, 1, 7'h00, 4, 13'h1234, 1);
        drive(1, 0, 13'h0000, 0, 0, 7'h00);
        tick("mid_hold", 1, 0, 7'h02, 1, 13'h0555, 1);
        drive(0, 0, 13'h0000, 0, 0, 7'h00);
        tick("mid_rst", 1, 0, 7'h02, 1, 13'h0555, 1);
        drive(1, 0, 13'h0000, 0, 0, 7'h00);
        tick("mid_after", 1, 1, 7'h00, 0, 13'h0000, 0);

        // Channel 0 stalled: 15 cycles there, then channel 1; next word goes to channel 2.
        drive(1, 1, 13'h0ABC, 0, 0, 7'h7E);
        tick("stall_acc", 1, 1, 7'h00, 0, 13'h0000, 0);
        drive(1, 0, 13'h0000, 0, 0, 7'h7E);
        for (int i = 0; i < STALL_MAX; i++)
            tick("stall_hold", 1, 0, 7'h01, 0, 13'h0ABC, 0);
        drive(1, 1, 13'h0DEF, 0, 0, 7'h7E);
        tick("stall_retarget", 1, 1, 7'h02, 1, 13'h0ABC, 0);
        drive(1, 0, 13'h0000, 0, 0, 7'h7E);
        tick("stall_next", 1, 1, 7'h04, 2, 13'h0DEF, 0);

        blk = '0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 32 == 0)
                blk = ($urandom_range(0, 2) == 0) ? '0 : NCH'(1 << $urandom_range(0, NCH - 1));
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, WIDTH'($urandom),
                  SELW'($urandom), 1'($urandom), NCH'($urandom | $urandom) & ~blk);
            tick("rand", 0, 0, '0, '0, '0, '0);
        end

        n_chk++;
        if (dut_del != m_del) begin
            n_err++;
            $display("FAIL deliveries: got %0d, want %0d", dut_del, m_del);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
